// File: rtl/demux_slot_router_pkg.sv
// Shared constants for the demux slot router and the datapath selector muxes.
// Plain localparams and one helper, no typedefs.
package demux_slot_router_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 16;

    // Number of channels addressed by a select field of the given width.
    function automatic int num_ch(input int selw);
        return 1 << selw;
    endfunction

endpackage

// File: rtl/demux_slot_router_slot.sv
// One-entry output buffer: load captures a word, drain empties it, clear drops it.
// Data only changes on load so a cleared or drained slot keeps its last word.
module demux_slot
    import demux_slot_router_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Clear wins over everything; a load in the same cycle as a drain refills the slot.
    always_comb begin
        // NOTE: defaults first so every path assigns the next-state, which keeps this a latch-free mux.
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: the data register is reset too, because out_data must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_slot_router.sv
// Registered 1-to-N demultiplexer: steers each accepted word into the one-entry slot of
// the selected channel, with independent valid/ready handshakes per channel.
module demux_slot_router
    import demux_slot_router_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int SELW  = SEL_W,
    parameter int NCH   = num_ch(SELW)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELW-1:0]      in_sel,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]     acc_count
);

    logic             accept;
    logic [NCH-1:0]   load_vec;
    logic [NCH-1:0]   drain_vec;
    logic [CNT_W-1:0] acc_count_q, acc_count_d;

    // Ready only looks at the addressed slot, so a stalled channel never blocks the others.
    assign in_ready  = !flush && (!out_valid[in_sel] || out_ready[in_sel]);
    assign accept    = in_valid && in_ready;
    assign drain_vec = out_valid & out_ready;

    always_comb begin
        load_vec = '0;
        for (int k = 0; k < NCH; k++) begin
            load_vec[k] = accept && (in_sel == SELW'(k));
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (flush),
            .load_i  (load_vec[k]),
            .drain_i (drain_vec[k]),
            .data_i  (in_data),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH])
        );
    end

    // accept is already false during flush, so the counter holds through a flush.
    always_comb begin
        acc_count_d = acc_count_q;
        if (accept) begin
            acc_count_d = acc_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count_q <= '0;
        end else begin
            acc_count_q <= acc_count_d;
        end
    end

    assign acc_count = acc_count_q;

endmodule
